// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Control-hazard unit for a five-stage pipeline that resolves branches in MEM.
// A table of 2-bit saturating counters (BHT) predicts conditional branches in
// ID.
// - A predicted-taken branch in ID is redirected early (NPCOp 101, flush IF/ID).
// - Resolution in MEM redirects jal/jalr and corrects mispredicted branches
//   (flush every pipeline register). A MEM redirect always beats an ID redirect.
//
// Configuration macro: BPU_DYNAMIC_EN
//   defined   - BHT storage is built and dynamic prediction is enabled.
//   undefined - no BHT; static not-taken prediction. id_pred_taken is tied to
//               0, and a MEM branch redirects (001) exactly when it is taken.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   id_valid        ID holds a valid instruction
//   id_is_br        ID instruction is a conditional branch
//   id_pc           PC of the ID instruction
//   id_pred_taken   BHT prediction for id_pc (MSB of the counter)
//   res_valid       MEM holds a valid instruction
//   res_npcop       NPCOp of the MEM instruction (000/001/010/100)
//   res_zero        branch condition outcome (1 = taken)
//   res_pred_taken  prediction carried down with the MEM instruction
//   res_pc          PC of the MEM instruction (selects the BHT entry to train)
//   npcop_out       NPC mux select: 000 PC+4, 001 branch target, 010 jal,
//                   100 jalr, 011 res_pc+4 (undo), 101 ID predicted target
//   flush           per-register flush vector (bit0 IF/ID, bit1 ID/EX, ...)
//   mispredict      MEM conditional branch mispredicted this cycle
// -----------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int PC_WIDTH    = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int FLUSH_DEPTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic                   id_is_br,
   input  logic [PC_WIDTH-1:0]    id_pc,
   output logic                   id_pred_taken,
   input  logic                   res_valid,
   input  logic [2:0]             res_npcop,
   input  logic                   res_zero,
   input  logic                   res_pred_taken,
   input  logic [PC_WIDTH-1:0]    res_pc,
   output logic [2:0]             npcop_out,
   output logic [FLUSH_DEPTH-1:0] flush,
   output logic                   mispredict
);

   localparam logic [2:0] NPC_SEQ    = 3'b000;
   localparam logic [2:0] NPC_BR     = 3'b001;
   localparam logic [2:0] NPC_JAL    = 3'b010;
   localparam logic [2:0] NPC_UNDO   = 3'b011;
   localparam logic [2:0] NPC_JALR   = 3'b100;
   localparam logic [2:0] NPC_ID_BR  = 3'b101;

   logic id_pred_s;    // prediction for the ID instruction
   logic pred_eff_s;   // prediction the MEM instruction was fetched under

`ifdef BPU_DYNAMIC_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   // Saturating 2-bit counter step: up on taken, down on not-taken.
   function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end else begin
         nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
      return nxt;
   endfunction

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       upd_cnt_d;
   logic [IDX_W-1:0] rd_idx_s;
   logic [IDX_W-1:0] wr_idx_s;
   logic             upd_en_s;
   logic             unused_pc_s;

   assign rd_idx_s    = id_pc[IDX_W+1:2];
   assign wr_idx_s    = res_pc[IDX_W+1:2];
   assign upd_en_s    = res_valid && (res_npcop == NPC_BR);
   assign id_pred_s   = bht_q[rd_idx_s][1];
   assign pred_eff_s  = res_pred_taken;
   assign unused_pc_s = ^{id_pc[PC_WIDTH-1:IDX_W+2], id_pc[1:0],
                          res_pc[PC_WIDTH-1:IDX_W+2], res_pc[1:0]};

   // Next value of the counter being trained by the MEM branch.
   always_comb begin
      upd_cnt_d = sat_cnt(bht_q[wr_idx_s], res_zero);
   end

   // BHT storage: reset to weakly not-taken; reset drops any pending update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (upd_en_s) begin
         bht_q[wr_idx_s] <= upd_cnt_d;
      end
   end
`else
   logic        unused_pc_s;
   logic [31:0] unused_cfg_s;

   // Static not-taken: nothing is ever predicted taken, so a MEM branch was
   // always fetched down the fall-through path.
   assign id_pred_s    = 1'b0;
   assign pred_eff_s   = 1'b0;
   assign unused_pc_s  = ^{clk, id_pc, res_pc, res_pred_taken};
   assign unused_cfg_s = 32'(BHT_ENTRIES);
`endif

   assign id_pred_taken = id_pred_s;

   logic is_br_s;
   logic is_jal_s;
   logic is_jalr_s;
   logic br_miss_s;
   logic mem_redir_s;
   logic id_redir_s;

   assign is_br_s     = (res_npcop == NPC_BR);
   assign is_jal_s    = (res_npcop == NPC_JAL);
   assign is_jalr_s   = (res_npcop == NPC_JALR);
   assign br_miss_s   = res_valid && is_br_s && (res_zero != pred_eff_s);
   assign mem_redir_s = (res_valid && (is_jal_s || is_jalr_s)) || br_miss_s;
   assign id_redir_s  = id_valid && id_is_br && id_pred_s;

   // Redirect arbitration: reset silences everything, MEM beats ID.
   always_comb begin
      npcop_out  = NPC_SEQ;
      flush      = '0;
      mispredict = 1'b0;
      if (rst) begin
         npcop_out  = NPC_SEQ;
         flush      = '0;
         mispredict = 1'b0;
      end else if (mem_redir_s) begin
         flush      = '1;
         mispredict = br_miss_s;
         case (res_npcop)
            NPC_JAL:  npcop_out = NPC_JAL;
            NPC_JALR: npcop_out = NPC_JALR;
            // Only mispredicted branches reach here: fix up toward the outcome.
            NPC_BR:   npcop_out = res_zero ? NPC_BR : NPC_UNDO;
            default:  npcop_out = NPC_SEQ;
         endcase
      end else if (id_redir_s) begin
         npcop_out  = NPC_ID_BR;
         flush      = FLUSH_DEPTH'(1);
         mispredict = 1'b0;
      end else begin
         npcop_out  = NPC_SEQ;
         flush      = '0;
         mispredict = 1'b0;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for branch_predict_unit. A behavioural model (integer
// counter array plus the redirect rules) predicts every output; directed steps
// follow the test plan, then a randomized run exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

`ifdef BPU_DYNAMIC_EN
   localparam bit DYN = 1'b1;
`else
   localparam bit DYN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic        id_is_br;
   logic [31:0] id_pc;
   logic        id_pred_taken;
   logic        res_valid;
   logic [2:0]  res_npcop;
   logic        res_zero;
   logic        res_pred_taken;
   logic [31:0] res_pc;
   logic [2:0]  npcop_out;
   logic [2:0]  flush;
   logic        mispredict;

   int tests;
   int fails;
   int bht_m [16];

   branch_predict_unit #(.PC_WIDTH(32), .BHT_ENTRIES(16), .FLUSH_DEPTH(3)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_is_br(id_is_br), .id_pc(id_pc),
      .id_pred_taken(id_pred_taken),
      .res_valid(res_valid), .res_npcop(res_npcop), .res_zero(res_zero),
      .res_pred_taken(res_pred_taken), .res_pc(res_pc),
      .npcop_out(npcop_out), .flush(flush), .mispredict(mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd16);
   endfunction

   // Model prediction for a PC (static mode never predicts taken).
   function automatic logic mpred(input logic [31:0] pc);
      return DYN && (bht_m[midx(pc)] >= 2);
   endfunction

   // One cycle: drive at negedge, check mid-low-phase, then advance the model.
   task automatic step(input logic r, input logic iv, input logic ib, input logic [31:0] ipc,
                       input logic rv, input logic [2:0] op, input logic z, input logic pt,
                       input logic [31:0] rpc);
      logic       ep;
      logic       rp;
      logic [2:0] en;
      logic [2:0] ef;
      logic       em;
      @(negedge clk);
      rst = r; id_valid = iv; id_is_br = ib; id_pc = ipc;
      res_valid = rv; res_npcop = op; res_zero = z; res_pred_taken = pt; res_pc = rpc;
      #2;
      ep = mpred(ipc);
      rp = DYN ? pt : 1'b0;
      en = 3'd0; ef = 3'd0; em = 1'b0;
      if (!r) begin
         if (rv && op == 3'd2)                 en = 3'd2;
         else if (rv && op == 3'd4)            en = 3'd4;
         else if (rv && op == 3'd1 && z && !rp) en = 3'd1;
         else if (rv && op == 3'd1 && !z && rp) en = 3'd3;
         if (en != 3'd0) ef = 3'b111;
         else if (iv && ib && ep) begin en = 3'd5; ef = 3'b001; end
         em = rv && (op == 3'd1) && (z != rp);
      end
      chk("id_pred_taken", 32'(id_pred_taken), 32'(ep));
      chk("npcop_out", 32'(npcop_out), 32'(en));
      chk("flush", 32'(flush), 32'(ef));
      chk("mispredict", 32'(mispredict), 32'(em));
      if (r) begin
         for (int i = 0; i < 16; i++) bht_m[i] = 1;
      end else if (rv && op == 3'd1) begin
         if (z) bht_m[midx(rpc)] = (bht_m[midx(rpc)] == 3) ? 3 : bht_m[midx(rpc)] + 1;
         else   bht_m[midx(rpc)] = (bht_m[midx(rpc)] == 0) ? 0 : bht_m[midx(rpc)] - 1;
      end
   endtask

   initial begin
      logic [31:0] pcs [4];
      logic [2:0]  ops [5];
      logic [31:0] ipc;
      logic [31:0] rpc;
      logic [2:0]  op;
      logic        pt;
      tests = 0; fails = 0;
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      rst = 1'b1; id_valid = 1'b0; id_is_br = 1'b0; id_pc = 32'h0;
      res_valid = 1'b0; res_npcop = 3'd0; res_zero = 1'b0; res_pred_taken = 1'b0; res_pc = 32'h0;

      // Reset, then the first misprediction at 0x40.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 1'b1, 1'b0, 32'h40);
      chk("plan_first_miss_npcop", 32'(npcop_out), 32'd1);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      // Train to strongly taken, then ID redirect, then undo in MEM.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 1'b1, DYN, 32'h40);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 1'b0, DYN, 32'h40);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      // MEM jalr beats a predicted-taken ID branch.
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 3'd4, 1'b0, 1'b0, 32'h100);
      chk("plan_jalr_wins", 32'(npcop_out), 32'd4);
      // Saturation at 0x80, read back through ID each time; aliasing with 0x40.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 3'd1, 1'b0, 1'b0, 32'h80);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 3'd1, 1'b1, 1'b0, 32'h80);
      step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      // res_valid low ignores a jal code; reset during a MEM branch.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd2, 1'b1, 1'b0, 32'h80);
      step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 3'd1, 1'b1, 1'b0, 32'h80);
      chk("plan_reset_flush", 32'(flush), 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      // Unknown NPCOp code in MEM behaves as sequential.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3'd7, 1'b1, 1'b0, 32'h44);

      // Randomized mixed traffic.
      pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h44; pcs[3] = 32'hC8;
      ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd4; ops[4] = 3'd1;
      for (int n = 0; n < 400; n++) begin
         ipc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 3)];
         rpc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 3)];
         op  = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : ops[$urandom_range(0, 4)];
         pt  = DYN ? 1'($urandom()) : 1'b0;
         step(($urandom_range(0, 49) == 0), 1'($urandom()), 1'($urandom()), ipc,
              ($urandom_range(0, 3) != 0), op, 1'($urandom()), pt, rpc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
